// File: rtl/i2c_master_write_8.sv
//------------------------------------------------------------------------------
// Module      : i2c_master_write_8
// Description : Single-byte I2C write master (START, adr+W, ACK, data, ACK, STOP).
//               Optional address-NACK retry enabled by macro I2C_MASTER_RETRY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2c_master_write_8 #(
    parameter int CLK_DIV   = 4,
    parameter int RETRY_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [6:0] adr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       nack,
    inout  wire        scl,
    inout  wire        sda
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_div;
    logic [1:0]  r_phase;
    logic [3:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic [1:0]  r_sda_sync;
    logic        r_ack_bad;
    logic        r_busy;
    logic        r_done;
    logic        r_nack;

    logic        w_accept;
    logic        w_tick;
    logic        w_slot_end;
    logic        w_last_bit;
    logic        w_retry;
    logic        w_last_try;
    logic [7:0]  w_retry_shift;
    logic        w_scl_low;
    logic        w_sda_low;

    assign w_accept   = (r_state == S_IDLE) && req && !r_busy;
    assign w_tick     = r_busy && (r_div == 16'(CLK_DIV - 1));
    assign w_slot_end = w_tick && (r_phase == 2'd3);
    assign w_last_bit = (r_bit == 4'd8);

`ifdef I2C_MASTER_RETRY_EN
    localparam int c_RW = $clog2(RETRY_MAX + 2);

    logic [c_RW-1:0] r_retry;
    logic [6:0]      r_adr;
    logic            r_addr_nack;

    assign w_retry       = r_addr_nack && (r_retry != c_RW'(RETRY_MAX));
    assign w_last_try    = (r_retry == c_RW'(RETRY_MAX));
    assign w_retry_shift = {r_adr, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retry     <= '0;
            r_adr       <= '0;
            r_addr_nack <= 1'b0;
        end else if (w_accept) begin
            r_retry     <= '0;
            r_adr       <= adr;
            r_addr_nack <= 1'b0;
        end else if (w_slot_end && (r_state == S_ADDR) && w_last_bit && r_ack_bad) begin
            r_addr_nack <= 1'b1;
        end else if (w_slot_end && (r_state == S_STOP) && w_retry) begin
            r_retry     <= r_retry + c_RW'(1);
            r_addr_nack <= 1'b0;
        end
    end
`else
    assign w_retry       = 1'b0;
    assign w_last_try    = 1'b1;
    assign w_retry_shift = r_shift;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Bus drive is decoded from state/phase; SDA only moves while SCL is held low.
    always_comb begin
        w_state_nxt = r_state;
        w_scl_low   = 1'b0;
        w_sda_low   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_START;
            end
            S_START: begin
                w_sda_low = (r_phase != 2'd0);
                w_scl_low = (r_phase == 2'd3);
                if (w_slot_end) w_state_nxt = S_ADDR;
            end
            S_ADDR, S_DATA: begin
                w_scl_low = (r_phase == 2'd0) || (r_phase == 2'd3);
                w_sda_low = !w_last_bit && !r_shift[7];
                if (w_slot_end && w_last_bit) begin
                    if ((r_state == S_ADDR) && !r_ack_bad) w_state_nxt = S_DATA;
                    else                                   w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_scl_low = (r_phase == 2'd0);
                w_sda_low = (r_phase < 2'd2);
                if (w_slot_end) w_state_nxt = w_retry ? S_START : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= '0;
            r_phase    <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_sda_sync <= 2'b11;
            r_ack_bad  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_sda_sync <= {r_sda_sync[0], sda};
            if (w_accept) begin
                r_div   <= '0;
                r_phase <= '0;
                r_bit   <= '0;
                r_shift <= {adr, 1'b0};
                r_data  <= data;
                r_busy  <= 1'b1;
                r_nack  <= 1'b0;
            end else if (r_busy) begin
                r_div <= w_tick ? '0 : r_div + 16'd1;
                if (w_tick) r_phase <= r_phase + 2'd1;
                if (w_tick && (r_phase == 2'd2) && w_last_bit &&
                    ((r_state == S_ADDR) || (r_state == S_DATA)))
                    r_ack_bad <= r_sda_sync[1];
                if (w_slot_end) begin
                    case (r_state)
                        S_ADDR, S_DATA: begin
                            if (w_last_bit) begin
                                r_bit <= '0;
                                if (r_ack_bad) begin
                                    // An address NACK only reports once no retry remains.
                                    if ((r_state == S_DATA) || w_last_try) r_nack <= 1'b1;
                                end else if (r_state == S_ADDR) begin
                                    r_shift <= r_data;
                                end
                            end else begin
                                r_bit   <= r_bit + 4'd1;
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                        S_STOP: begin
                            if (w_retry) begin
                                r_shift <= w_retry_shift;
                            end else begin
                                r_busy <= 1'b0;
                                r_done <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign scl  = w_scl_low ? 1'b0 : 1'bz;
    assign sda  = w_sda_low ? 1'b0 : 1'bz;
    assign busy = r_busy;
    assign done = r_done;
    assign nack = r_nack;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_write_8.sv
//------------------------------------------------------------------------------
// Module      : tb_i2c_master_write_8
// Description : Directed self-checking bench with a behavioural expander slave.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_master_write_8;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [6:0] adr;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       nack;
    wire        scl;
    wire        sda;

    pullup (scl);
    pullup (sda);

    logic sda_low;
    assign sda = sda_low ? 1'b0 : 1'bz;

    i2c_master_write_8 #(.CLK_DIV(CLK_DIV), .RETRY_MAX(3)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .adr  (adr),
        .data (data),
        .busy (busy),
        .done (done),
        .nack (nack),
        .scl  (scl),
        .sda  (sda)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave at address 0x20 plus bus monitor
    int          starts, stops, nbits, byte_idx, got_n, done_cnt, ack_from;
    logic [63:0] got_bits;
    logic [7:0]  sh;
    logic        ack_data;

    always @(negedge sda) if (scl === 1'b1) begin
        starts++;
        nbits    = 0;
        byte_idx = 0;
    end

    always @(posedge sda) if (scl === 1'b1) begin
        stops++;
        if (nbits == 1) begin
            got_bits = got_bits >> 1;
            got_n--;
        end
        nbits   = 0;
        sda_low = 1'b0;
    end

    always @(posedge scl) begin
        if (nbits < 8) sh = {sh[6:0], sda};
        got_bits = {got_bits[62:0], sda};
        got_n++;
        nbits++;
    end

    always @(negedge scl) begin
        if (nbits == 8) begin
            if (byte_idx == 0) sda_low = (sh[7:1] == 7'h20) && (starts >= ack_from);
            else               sda_low = ack_data;
        end else if (nbits == 9) begin
            sda_low = 1'b0;
            nbits   = 0;
            byte_idx++;
        end
    end

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        starts   = 0;
        stops    = 0;
        nbits    = 0;
        byte_idx = 0;
        got_n    = 0;
        got_bits = '0;
        done_cnt = 0;
        sda_low  = 1'b0;
    endtask

    task automatic start_xfer(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        req  = 1'b1;
        adr  = a;
        data = d;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        check("busy_after_accept", 64'(busy), 64'd1);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_until(input int n);
        while (cyc < acc_cyc + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_done(input string tag, input int n, input logic exp_nack);
        wait_until(n - 1);
        check({tag, "_done_early"}, 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_nack"}, 64'(nack), 64'(exp_nack));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        adr      = '0;
        data     = '0;
        ack_from = 1;
        ack_data = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_nack", 64'(nack), 64'd0);
        check("rst_scl", 64'(scl), 64'd1);
        check("rst_sda", 64'(sda), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        clear_mon();

        // ACK write 0x20 / 0xA5
        start_xfer(7'h20, 8'hA5);
        expect_done("ack", 80 * CLK_DIV, 1'b0);
        check("ack_nbits", 64'(got_n), 64'd18);
        check("ack_bits", got_bits, 64'({8'h40, 1'b0, 8'hA5, 1'b0}));
        check("ack_starts", 64'(starts), 64'd1);
        check("ack_stops", 64'(stops), 64'd1);

        // Address NACK
        repeat (5) @(posedge clk);
        clear_mon();
        start_xfer(7'h21, 8'hFF);
`ifdef I2C_MASTER_RETRY_EN
        expect_done("anack", 4 * 44 * CLK_DIV, 1'b1);
        check("anack_starts", 64'(starts), 64'd4);
        check("anack_stops", 64'(stops), 64'd4);
`else
        expect_done("anack", 44 * CLK_DIV, 1'b1);
        check("anack_nbits", 64'(got_n), 64'd9);
        check("anack_bits", got_bits, 64'({8'h42, 1'b1}));
        check("anack_starts", 64'(starts), 64'd1);
        check("anack_stops", 64'(stops), 64'd1);
`endif
        repeat (10) @(posedge clk);
        #1;
        check("nack_held", 64'(nack), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("nack_reset", 64'(nack), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);

`ifdef I2C_MASTER_RETRY_EN
        // Slave answers on the third attempt
        clear_mon();
        ack_from = 3;
        start_xfer(7'h20, 8'h66);
        expect_done("retry3", (2 * 44 + 80) * CLK_DIV, 1'b0);
        check("retry3_starts", 64'(starts), 64'd3);
        check("retry3_stops", 64'(stops), 64'd3);
        ack_from = 1;
        repeat (5) @(posedge clk);
`endif

        // Data NACK
        clear_mon();
        ack_data = 1'b0;
        start_xfer(7'h20, 8'h3C);
        expect_done("dnack", 80 * CLK_DIV, 1'b1);
        check("dnack_bits", got_bits, 64'({8'h40, 1'b0, 8'h3C, 1'b1}));
        check("dnack_starts", 64'(starts), 64'd1);
        check("dnack_stops", 64'(stops), 64'd1);
        ack_data = 1'b1;
        repeat (5) @(posedge clk);

        // req while busy is ignored
        clear_mon();
        start_xfer(7'h20, 8'h5A);
        wait_until(99);
        @(negedge clk);
        req  = 1'b1;
        adr  = 7'h30;
        data = 8'h11;
        @(negedge clk);
        req = 1'b0;
        expect_done("busyreq", 80 * CLK_DIV, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("busyreq_done_cnt", 64'(done_cnt), 64'd1);
        check("busyreq_bits", got_bits, 64'({8'h40, 1'b0, 8'h5A, 1'b0}));
        check("busyreq_starts", 64'(starts), 64'd1);
        check("busyreq_idle", 64'(busy), 64'd0);

        // Reset during DATA slot 4 (ph0, SCL held low)
        clear_mon();
        start_xfer(7'h20, 8'hC3);
        wait_until(209);
        check("mid_scl_low", 64'(scl), 64'd0);
        check("mid_busy", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_scl", 64'(scl), 64'd1);
        check("mid_rst_sda", 64'(sda), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_nack", 64'(nack), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        clear_mon();
        start_xfer(7'h20, 8'h81);
        expect_done("post_rst", 80 * CLK_DIV, 1'b0);
        check("post_rst_bits", got_bits, 64'({8'h40, 1'b0, 8'h81, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/i2c_master_write_8.md
Name: i2c_master_write_8

Overview:
- Single-byte I2C write master that drives the SDA/SCL bus to the board-level 8-bit I2C expander slaves.
- Host logic presents a 7-bit device address and a data byte with a request strobe.
- The block generates START, address+W, ACK check, data byte, ACK check and STOP, then reports completion and NACK status.
- It sits directly upstream of the expander slave on the same bus.

Parameters:
- CLK_DIV, 4: clk cycles per quarter-bit tick; legal range 2..65535. One SCL bit is 4*CLK_DIV clk cycles.
- RETRY_MAX, 3: address-NACK retries; used only when I2C_MASTER_RETRY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  transfer request; sampled when busy=0.
- adr  input  7  target device address.
- data  input  8  byte to write.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle completion pulse.
- nack  output  1  last transfer ended on a NACK; valid when done=1, held until the next accept.
- scl  inout  1  open-drain clock; driven 0 or z.
- sda  inout  1  open-drain data; driven 0 or z.

Behaviour:
- Reset (synchronous, active-high):
  - scl=z, sda=z, busy=0, done=0, nack=0.
  - State goes to IDLE; tick divider and bit counters are cleared.
  - Reset asserted mid-transfer releases both lines on the next clk edge. No STOP is generated.
- Tick generator:
  - Divider counts 0..CLK_DIV-1 while busy=1; tick=1 when the count equals CLK_DIV-1.
  - Divider is cleared on accept.
  - Each tick advances phase 0..3; the 4 phases form one bit slot.
- IDLE:
  - scl=z, sda=z.
  - If req=1 and busy=0: latch adr/data into shift registers, busy<=1, nack<=0, go to START.
  - req while busy=1 is ignored; no queuing.
- START (one slot):
  - ph0: scl=z, sda=z.
  - ph1 and ph2: sda=0.
  - ph3: scl=0.
  - Then go to ADDR.
- Bit slot (ADDR and DATA states):
  - ph0: scl=0; sda=0 if the current bit is 0, else z. Bits go out MSB first.
  - ph1 and ph2: scl=z.
  - ph3: scl=0.
  - SDA changes only in ph0, i.e. while SCL is low.
- ADDR: 9 slots.
  - Slots 1-8 send {adr,1'b0} (R/W=0).
  - Slot 9 releases sda and samples sda on the ph2 tick: 0=ACK, 1=NACK.
  - ACK: go to DATA. NACK: nack<=1, go to STOP.
- DATA: 9 slots.
  - Slots 1-8 send data[7:0].
  - Slot 9 samples ACK the same way; NACK sets nack<=1.
  - Then go to STOP.
- STOP (one slot):
  - ph0: scl=0, sda=0.
  - ph1: scl=z, sda=0.
  - ph2 and ph3: scl=z, sda=z.
  - On the ph3 tick: done<=1 for one cycle, busy<=0, go to IDLE.
- Latency:
  - Successful transfer = 20 slots = 80 ticks.
  - done is high in clk cycle 80*CLK_DIV after the accepting edge.
  - Address NACK = 11 slots, so done at 44*CLK_DIV.
- Sampling and synchronization:
  - The block never samples scl; no clock-stretching or arbitration support.
  - sda input passes through a 2-flop synchronizer before ACK sampling.

Optional Feature:
- Macro: I2C_MASTER_RETRY_EN.
- Defined:
  - On address NACK, generate STOP, then re-enter START immediately without returning to IDLE; busy stays 1.
  - Up to RETRY_MAX retries, i.e. RETRY_MAX+1 attempts in total.
  - nack=1 only if the final attempt also NACKs.
  - A data NACK is never retried.
  - The retry counter clears on accept and on reset.
- Not defined: an address NACK goes straight to STOP, done, nack=1. No retry counter is synthesized.

Test Plan:
- ACK write:
  - Stimulus: CLK_DIV=4, slave at 0x20 ACKs; req with adr=0x20, data=0xA5.
  - Expected: START; SCL rises sample bits 0,1,0,0,0,0,0,0, then ACK, then 1,0,1,0,0,1,0,1, then ACK; STOP; done at cycle 320; nack=0; busy=0 afterward.
- Address NACK, macro off:
  - Stimulus: adr=0x21, no slave responds.
  - Expected: STOP after the 9th slot; done at cycle 176; nack=1; data bits never appear on the bus.
- Address NACK, macro on:
  - Stimulus: I2C_MASTER_RETRY_EN defined, RETRY_MAX=3, slave NACKs always.
  - Expected: exactly 4 START/STOP pairs, then done with nack=1.
  - Variant: slave ACKs on the 3rd attempt. Expected: data sent, nack=0.
- Data NACK:
  - Stimulus: slave ACKs the address, NACKs the data.
  - Expected: single STOP, nack=1, no retry even with the macro on.
- req during busy:
  - Stimulus: pulse req with adr=0x30 at cycle 100 of a transfer.
  - Expected: ignored; bus traffic carries only the first transfer; exactly one done pulse.
- Reset mid-transfer:
  - Stimulus: assert reset during DATA slot 4.
  - Expected: scl=z, sda=z, busy=0, done=0, nack=0 one edge later; a new req after reset completes normally.
